// File: rtl/inst_mem_server.sv
// Instruction memory with a byte-serial program upload path and a registered fetch port.
// The CPU is held while an upload runs; fetches return NOP during that time.
module inst_mem_server #(
  parameter int ADDR_W = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       fetch_addr,
  output logic [31:0]       Instruction,
  output logic              fetch_err,
  input  logic              upg_mode,
  input  logic [7:0]        upg_byte,
  input  logic              upg_byte_valid,
  output logic              upg_byte_ready,
  output logic              upg_done,
  output logic [ADDR_W:0]   upg_word_count,
  output logic              cpu_hold
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic              r_modePrev;
  logic [1:0]        r_byteCnt;
  logic [ADDR_W-1:0] r_wordAddr;
  logic [ADDR_W:0]   r_wordCount;
  logic [23:0]       r_partial;
  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_instr;
  logic              r_err;

  logic              w_modeRise;
  logic              w_accept;
  logic              w_wordDone;
  logic              w_lastWord;
  logic              w_loadEntry;
  logic              w_outOfRange;
  logic [ADDR_W-1:0] w_fetchIdx;

  assign w_modeRise   = upg_mode & ~r_modePrev;
  assign w_accept     = upg_byte_valid && (r_state == LOAD);
  assign w_wordDone   = w_accept && (r_byteCnt == 2'd3);
  assign w_lastWord   = w_wordDone && (&r_wordAddr);
  assign w_loadEntry  = (r_state != LOAD) && (w_nextState == LOAD);
  assign w_outOfRange = |(fetch_addr >> (ADDR_W + 2));
  assign w_fetchIdx   = fetch_addr[ADDR_W+1:2];

  assign upg_byte_ready = (r_state == LOAD);
  assign cpu_hold       = (r_state == LOAD);
  assign upg_done       = (r_state == DONE);
  assign upg_word_count = r_wordCount;
  assign Instruction    = r_instr;
  assign fetch_err      = r_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: if (w_modeRise) w_nextState = LOAD;
      LOAD:       if (w_lastWord || !upg_mode) w_nextState = DONE;
      default:    w_nextState = IDLE;
    endcase
  end

  // Upload datapath: counters are cleared on every entry into LOAD so a
  // previous partial word can never leak into the next upload.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_modePrev  <= 1'b0;
      r_byteCnt   <= 2'd0;
      r_wordAddr  <= '0;
      r_wordCount <= '0;
      r_partial   <= '0;
    end else begin
      r_modePrev <= upg_mode;
      if (w_loadEntry) begin
        r_byteCnt   <= 2'd0;
        r_wordAddr  <= '0;
        r_wordCount <= '0;
        r_partial   <= '0;
      end else if (w_wordDone) begin
        r_byteCnt   <= 2'd0;
        r_wordCount <= r_wordCount + (ADDR_W+1)'(1);
        if (!w_lastWord) r_wordAddr <= r_wordAddr + ADDR_W'(1);
      end else if (w_accept) begin
        r_byteCnt <= r_byteCnt + 2'd1;
        case (r_byteCnt)
          2'd0:    r_partial[7:0]   <= upg_byte;
          2'd1:    r_partial[15:8]  <= upg_byte;
          default: r_partial[23:16] <= upg_byte;
        endcase
      end
    end
  end

  // Memory contents survive reset, so the array has no reset branch.
  always_ff @(posedge clock) begin
    if (w_wordDone) r_mem[r_wordAddr] <= {upg_byte, r_partial};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_instr <= 32'd0;
      r_err   <= 1'b0;
    end else if (r_state == LOAD) begin
      r_instr <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_outOfRange) begin
      r_instr <= 32'd0;
      r_err   <= 1'b1;
    end else begin
      r_instr <= r_mem[w_fetchIdx];
      r_err   <= |fetch_addr[1:0];
    end
  end

endmodule

// File: doc/inst_mem_server.md
INST_MEM_SERVER -- requirements
Module: inst_mem_server

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning word-address width; DEPTH = 2^ADDR_W words.
REQ-002 SHALL have port clock  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port fetch_addr  input  32  byte address of instruction (CPU PC).
REQ-005 SHALL have port Instruction  output  32  registered instruction word returned to fetch unit.
REQ-006 SHALL have port fetch_err  output  1  registered flag: last fetch misaligned or out of range.
REQ-007 SHALL have port upg_mode  input  1  level request to enter program-upload mode.
REQ-008 SHALL have port upg_byte  input  8  upload data byte.
REQ-009 SHALL have port upg_byte_valid  input  1  upg_byte is valid this cycle.
REQ-010 SHALL have port upg_byte_ready  output  1  block accepts a byte this cycle.
REQ-011 SHALL have port upg_done  output  1  upload finished; held until next upload starts.
REQ-012 SHALL have port upg_word_count  output  ADDR_W+1  words written in current/last upload.
REQ-013 SHALL have port cpu_hold  output  1  CPU must hold PC/reset while asserted.

Function
REQ-014 SHALL contain a DEPTH x 32 word array, written only by the upload path.
REQ-015 SHALL implement states IDLE, LOAD, DONE.
REQ-016 IDLE -> LOAD on rising edge of upg_mode (upg_mode=1, previous-cycle sample 0); DONE -> LOAD likewise.
REQ-017 On LOAD entry SHALL clear byte counter (2 bits), word address, upg_word_count, partial-word register.
REQ-018 upg_byte_ready SHALL equal (state==LOAD); byte accepted only when upg_byte_valid && upg_byte_ready.
REQ-019 Byte assembly little-endian: 1st accepted byte -> bits[7:0], 2nd [15:8], 3rd [23:16], 4th [31:24].
REQ-020 On 4th accepted byte SHALL write assembled word at word address in that same clock edge, increment word address and upg_word_count, reset byte counter.
REQ-021 Write of word DEPTH-1 SHALL transition LOAD -> DONE on same edge; no further bytes accepted; no address wrap.
REQ-022 upg_mode deasserted in LOAD SHALL transition LOAD -> DONE; partial word (1-3 bytes) discarded, not written.
REQ-023 upg_done SHALL equal (state==DONE); cpu_hold SHALL equal (state==LOAD).
REQ-024 Fetch read latency 1 cycle: Instruction at edge N+1 reflects fetch_addr sampled at edge N.
REQ-025 Word index = fetch_addr[ADDR_W+1:2].
REQ-026 If fetch_addr[31:ADDR_W+2] != 0: Instruction <= 0, fetch_err <= 1.
REQ-027 If fetch_addr[1:0] != 0 (and in range): Instruction <= word at index, fetch_err <= 1.
REQ-028 While state==LOAD: Instruction <= 0 (NOP), fetch_err <= 0, regardless of fetch_addr; no read/write collision visible.
REQ-029 Write and fetch of same index in same edge outside LOAD cannot occur; no bypass required.

Reset
REQ-030 reset=1 SHALL immediately force state IDLE, Instruction 0, fetch_err 0, upg_done 0, cpu_hold 0, upg_byte_ready 0, upg_word_count 0, byte counter 0, upg_mode edge register 0.
REQ-031 Memory array contents SHALL NOT be altered by reset.
REQ-032 reset mid-LOAD SHALL abort upload; partial word discarded; already-written words retained; upg_mode held high across reset release SHALL count as a rising edge and start a new LOAD.

Verification
REQ-033 Upload 8 bytes 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 then drop upg_mode -> upg_word_count=2, upg_done=1; fetch 0x0 -> 0x00000013, fetch 0x4 -> 0x00100093, one cycle later each.
REQ-034 Upload 6 bytes then drop upg_mode -> upg_word_count=1; word 1 unchanged from prior contents.
REQ-035 ADDR_W=2: stream 20 bytes with valid held -> 16 accepted, ready=0 after 16th, DONE, upg_word_count=4.
REQ-036 Fetch 0x2 -> fetch_err=1, data = word 0; fetch 0x00010000 (ADDR_W=14) -> Instruction 0, fetch_err=1.
REQ-037 Assert reset after 3 words and 2 bytes -> all outputs reset within same cycle, words 0-2 still readable after reset release.
REQ-038 During LOAD, fetch_addr=0x0 -> Instruction=0, cpu_hold=1; after DONE -> Instruction= uploaded word 0.
